flght_seq: RTL
==============

// Module: flght_seq
// PURPOSE
//  Arming/calibration sequencer in front of flght_cntrl. Drives its inertial_cal and thrst inputs.
//  Drives the inertial integrator's strt_cal. Gates motors via motors_off.
//  Watches the inertial vld stream and forces a safe FAULT state on calibration timeout or sensor loss.
// PARAMETERS
//  CAL_TMO_CYCLES  default 2**20  max cycles in CAL waiting for cal_done before FAULT
//  WDOG_CYCLES     default 2**16  max cycles between vld pulses while ARMED before FAULT
//  RAMP_STEP       default 4      max thrst change per cycle (THRST_RAMP_EN only)
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  asynchronous active-low reset
//  arm_req       in   1  1-cycle pulse: start calibration/arming
//  disarm_req    in   1  1-cycle pulse: return to IDLE, clears FAULT
//  cal_done      in   1  inertial integrator calibration complete (pulse or level)
//  vld           in   1  new inertial reading valid (pulse)
//  thrst_cmd     in   9  commanded thrust, unsigned
//  strt_cal      out  1  1-cycle pulse to inertial integrator
//  inertial_cal  out  1  to flght_cntrl; high for all of CAL
//  thrst         out  9  thrust to flght_cntrl, unsigned
//  motors_off    out  1  high forces ESC outputs to zero speed
//  armed         out  1  high in ARMED
//  fault         out  1  high in FAULT
// BEHAVIOUR
//  - All outputs are registered and change 1 cycle after the causing input edge.
//  - Reset: state IDLE, strt_cal=0, inertial_cal=0, thrst=0, motors_off=1, armed=0, fault=0. Both counters = 0.
//  - IDLE: motors_off=1, thrst=0.
//    - arm_req & !disarm_req -> CAL. strt_cal pulses in the first CAL cycle only; cal counter cleared.
//  - CAL: inertial_cal=1, motors_off=0, thrst=0; cal counter increments every cycle.
//    - disarm_req -> IDLE. Highest priority.
//    - else cal_done -> ARMED.
//    - else counter == CAL_TMO_CYCLES-1 -> FAULT.
//  - ARMED: armed=1, motors_off=0, thrst tracks thrst_cmd.
//    - wdog counter is cleared on any cycle with vld=1, otherwise increments.
//    - disarm_req -> IDLE (priority). Else counter == WDOG_CYCLES-1 with vld=0 -> FAULT.
//    - The counter is cleared on ARMED entry.
//  - FAULT: fault=1, motors_off=1, thrst=0. arm_req is ignored; only disarm_req -> IDLE.
//  - Simultaneous events:
//    - disarm_req beats every other event in every state.
//    - vld and timeout in the same cycle: vld wins, no FAULT.
//    - cal_done and timeout in the same cycle: cal_done wins.
//  - arm_req in CAL/ARMED is ignored; it does not restart calibration.
//  - Leaving ARMED for any reason: thrst=0 in the very next cycle.
//  - Counters saturate at their terminal value and never wrap.
//  - Reset mid-operation: immediate return to the reset values (asynchronous).
// CONFIGURATION
//  THRST_RAMP_EN defined:
//    - In ARMED, each cycle thrst moves toward thrst_cmd by min(|thrst_cmd-thrst|, RAMP_STEP).
//    - Compute in 10 bits; result is never outside 0..511.
//    - On ARMED entry thrst starts ramping from 0.
//  THRST_RAMP_EN undefined: in ARMED, thrst <= thrst_cmd every cycle (1-cycle latency). RAMP_STEP unused.
// STRUCTURE
//  - flght_seq_pkg: typedef enum logic [1:0] {IDLE, CAL, ARMED, FAULT} seq_state_t; localparam THRST_W = 9.
//  - Sub-module tmo_cntr #(TERM): clr, en, expired, saturating. Instanced twice: cal timeout and vld watchdog.
//  - Top: state register, next-state logic, output registers, optional ramp logic.
// TESTING  (bench overrides CAL_TMO_CYCLES=100, WDOG_CYCLES=50, RAMP_STEP=4)
//  - Reset: rst_n=0 mid-ARMED -> same cycle motors_off=1, armed=0, thrst=0, state IDLE.
//  - Normal arm:
//    - arm_req pulse -> next cycle strt_cal=1 for 1 cycle, inertial_cal=1.
//    - cal_done at cycle 40 -> next cycle armed=1, inertial_cal=0.
//    - thrst_cmd=9'h0C8 -> thrst=0x0C8 one cycle later (ramp off).
//  - Cal timeout: arm_req, no cal_done -> fault=1 exactly 100 cycles after CAL entry.
//    - arm_req then ignored; disarm_req -> IDLE, fault=0.
//  - Watchdog:
//    - ARMED, vld every 49 cycles for 500 cycles -> no FAULT.
//    - Then vld stops -> fault=1, thrst=0 after 50 cycles.
//  - Priority: disarm_req and cal_done in the same CAL cycle -> IDLE, armed stays 0.
//  - THRST_RAMP_EN: ARMED, thrst_cmd 0 -> 0x0C8 -> thrst 4,8,...,200 over 50 cycles.
//    - Then thrst_cmd=0x0C6 -> thrst=0x0C6 in 1 cycle.

Source files
------------

// File: rtl/flght_seq_pkg.sv
// Shared types and helpers for the arming/calibration sequencer.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package flght_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAL   = 2'd1,
    ARMED = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  localparam int THRST_W = 9;

  // Move cur toward tgt by at most step. Done in 10 bits so neither the
  // difference nor the sum can wrap; the result always lies between cur and
  // tgt, so it fits back into THRST_W bits.
  function automatic logic [THRST_W-1:0] ramp_toward(
    input logic [THRST_W-1:0] cur,
    input logic [THRST_W-1:0] tgt,
    input logic [9:0]         step
  );
    logic [9:0] c;
    logic [9:0] t;
    logic [9:0] d;
    logic [9:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    d = (t >= c) ? (t - c) : (c - t);
    if (d > step) d = step;
    r = (t >= c) ? (c + d) : (c - d);
    return r[THRST_W-1:0];
  endfunction

endpackage

// File: rtl/flght_seq_tmo.sv
// Saturating timeout counter: counts enabled cycles, flags the terminal value.
// Latency: expired reflects the registered count (no input-to-output path).
// Backpressure: none; clr has priority over en, count holds at TERM-1.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count -> 0)
//   clr         synchronous clear of the count
//   en          increment enable
//   expired     count has reached TERM-1
module tmo_cntr #(
  parameter int unsigned TERM = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned    W    = (TERM > 1) ? $clog2(TERM) : 1;
  localparam logic [W-1:0]   LAST = W'(TERM - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/flght_seq.sv
// Arming/calibration sequencer gating flght_cntrl thrust and motors.
// Latency: every output is registered, 1 cycle after the causing input.
// Backpressure: none; single-cycle request pulses, disarm_req always wins.
//
// Optional feature: define THRST_RAMP_EN to slew-limit thrst by RAMP_STEP
// per cycle while ARMED; otherwise thrst follows thrst_cmd directly.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   arm_req       pulse: IDLE -> CAL
//   disarm_req    pulse: any state -> IDLE (clears FAULT)
//   cal_done      calibration complete from inertial integrator
//   vld           inertial sample strobe, feeds the ARMED watchdog
//   thrst_cmd     commanded thrust
//   strt_cal      1-cycle pulse on CAL entry
//   inertial_cal  high throughout CAL
//   thrst         thrust to flght_cntrl (zero outside ARMED)
//   motors_off    high in IDLE and FAULT
//   armed, fault  state indicators
module flght_seq
  import flght_seq_pkg::*;
#(
  parameter int unsigned CAL_TMO_CYCLES = 2**20,
  parameter int unsigned WDOG_CYCLES    = 2**16,
  parameter int unsigned RAMP_STEP      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_req,
  input  logic               disarm_req,
  input  logic               cal_done,
  input  logic               vld,
  input  logic [THRST_W-1:0] thrst_cmd,
  output logic               strt_cal,
  output logic               inertial_cal,
  output logic [THRST_W-1:0] thrst,
  output logic               motors_off,
  output logic               armed,
  output logic               fault
);

  // A zero step would freeze the ramp; anything above full scale is meaningless.
  if ((RAMP_STEP < 1) || (RAMP_STEP > 511)) begin : g_bad_ramp_step
    $error("flght_seq: RAMP_STEP must be in 1..511");
  end

  seq_state_t state_q, state_d;
  logic       cal_exp;
  logic       wdog_exp;

  logic               strt_cal_q, strt_cal_d;
  logic               inertial_cal_q, inertial_cal_d;
  logic               motors_off_q, motors_off_d;
  logic               armed_q, armed_d;
  logic               fault_q, fault_d;
  logic [THRST_W-1:0] thrst_q, thrst_d;

  // Held at zero outside CAL, so it starts from zero on every CAL entry.
  tmo_cntr #(.TERM(CAL_TMO_CYCLES)) u_cal_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != CAL),
    .en      (state_q == CAL),
    .expired (cal_exp)
  );

  // Held at zero outside ARMED and restarted by every vld strobe.
  tmo_cntr #(.TERM(WDOG_CYCLES)) u_wdog_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state_q != ARMED) || vld),
    .en      (state_q == ARMED),
    .expired (wdog_exp)
  );

  always_comb begin
    state_d = state_q;
    if (disarm_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm_req) state_d = CAL;
        CAL: begin
          if (cal_done)     state_d = ARMED;
          else if (cal_exp) state_d = FAULT;
        end
        ARMED:   if (!vld && wdog_exp) state_d = FAULT;
        default: state_d = state_q;   // FAULT waits for disarm_req
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    strt_cal_d     = (state_q == IDLE) && (state_d == CAL);
    inertial_cal_d = (state_d == CAL);
    motors_off_d   = (state_d == IDLE) || (state_d == FAULT);
    armed_d        = (state_d == ARMED);
    fault_d        = (state_d == FAULT);
    thrst_d        = '0;
    if (state_d == ARMED) begin
`ifdef THRST_RAMP_EN
      // thrst_q is zero in every other state, so ARMED entry ramps from 0.
      thrst_d = ramp_toward(thrst_q, thrst_cmd, 10'(RAMP_STEP));
`else
      thrst_d = thrst_cmd;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      strt_cal_q     <= 1'b0;
      inertial_cal_q <= 1'b0;
      motors_off_q   <= 1'b1;
      armed_q        <= 1'b0;
      fault_q        <= 1'b0;
      thrst_q        <= '0;
    end else begin
      state_q        <= state_d;
      strt_cal_q     <= strt_cal_d;
      inertial_cal_q <= inertial_cal_d;
      motors_off_q   <= motors_off_d;
      armed_q        <= armed_d;
      fault_q        <= fault_d;
      thrst_q        <= thrst_d;
    end
  end

  assign strt_cal     = strt_cal_q;
  assign inertial_cal = inertial_cal_q;
  assign motors_off   = motors_off_q;
  assign armed        = armed_q;
  assign fault        = fault_q;
  assign thrst        = thrst_q;

endmodule
